// File: rtl/pll_reconfig_pkg.sv
// rtl/pll_reconfig_pkg.sv - register map, script tables and state type for pll_reconfig_seq
// Purpose: shared definitions for the PLL reconfiguration sequencer.
//   - reconfig controller register addresses
//   - script entry type and the NTSC / PAL preset scripts
//   - sequencer state enum
package pll_reconfig_pkg;

  localparam int SCRIPT_LEN = 8;
  localparam int TIMER_W    = 16;

  localparam logic [5:0] REG_MODE   = 6'd0;
  localparam logic [5:0] REG_STATUS = 6'd1;
  localparam logic [5:0] REG_START  = 6'd2;
  localparam logic [5:0] REG_M      = 6'd4;
  localparam logic [5:0] REG_C      = 6'd5;
  localparam logic [5:0] REG_K      = 6'd7;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } script_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_GAP,
    ST_SETTLE,
    ST_WAIT_LOCK
  } state_e;

  // MODE data 0 selects waitrequest mode. C writes carry the counter index
  // in data[22:18] and high/low counts in data[15:8]/data[7:0].
  localparam script_entry_t PRESET_NTSC [SCRIPT_LEN] = '{
    '{REG_MODE,  32'h0000_0000},
    '{REG_M,     32'h0000_0909},
    '{REG_C,     32'h0000_0303},
    '{REG_C,     32'h0004_0606},
    '{REG_C,     32'h0008_0C0C},
    '{REG_C,     32'h000C_4848},
    '{REG_K,     32'h6D3A_06D4},
    '{REG_START, 32'h0000_0001}
  };

  localparam script_entry_t PRESET_PAL [SCRIPT_LEN] = '{
    '{REG_MODE,  32'h0000_0000},
    '{REG_M,     32'h0000_0A09},
    '{REG_C,     32'h0000_0403},
    '{REG_C,     32'h0004_0707},
    '{REG_C,     32'h0008_0E0E},
    '{REG_C,     32'h000C_3C3C},
    '{REG_K,     32'h1E0F_5A2B},
    '{REG_START, 32'h0000_0001}
  };

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// rtl/pll_reconfig_seq_if.sv - reconfig controller management bus
// Purpose: Avalon-MM style write-only management port of the PLL reconfig controller.
//   mgmt_address     register address
//   mgmt_write       write strobe
//   mgmt_writedata   write data
//   mgmt_waitrequest controller stall
interface pll_reconfig_seq_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_write,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_write,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_reconfig_seq_sync_ff.sv
// rtl/pll_reconfig_seq_sync_ff.sv - multi-flop bit synchroniser
// Purpose: bring an asynchronous level into the clk domain.
//   clk, rst  clock, async active-high reset (flops clear to 0)
//   d         asynchronous input
//   q         synchronised output, STAGES cycles of latency
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reconfig_seq.sv
// rtl/pll_reconfig_seq.sv - NTSC/PAL PLL reconfiguration sequencer
// Purpose: when the synchronised video-standard selection differs from the
// configuration last applied, replay that standard's register script into the
// PLL reconfig controller, let the PLL settle, then wait for relock.
//   refclk, rst  50 MHz reference clock, async active-high reset
//   mode_sel     0=NTSC, 1=PAL (asynchronous level)
//   pll_locked   PLL lock indicator (asynchronous)
//   mgmt         reconfig controller management bus, master side
//   busy         sequence in progress
//   done         one-cycle pulse on successful relock
//   error        sticky relock-timeout flag
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_WRITES    = SCRIPT_LEN,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               mode_sel,
  input  logic               pll_locked,
  pll_reconfig_seq_if.master mgmt,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int IDX_W = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_WRITES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);

  logic mode_s;
  logic locked_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_mode (
    .clk (refclk),
    .rst (rst),
    .d   (mode_sel),
    .q   (mode_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  state_e               state_q,   state_d;
  logic                 target_q,  target_d;
  logic                 applied_q, applied_d;
  logic [IDX_W-1:0]     idx_q,     idx_d;
  logic [TIMER_W-1:0]   timer_q,   timer_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic                 error_q,   error_d;

  script_entry_t entry;
  logic          wr_active;

  always_comb begin
    entry = target_q ? PRESET_PAL[idx_q] : PRESET_NTSC[idx_q];
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    applied_d = applied_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    case (state_q)
      ST_IDLE: begin
        // Pending changes made while busy are only looked at here, so the
        // latest level always wins.
        if (mode_s != applied_q) begin
          target_d  = mode_s;
          applied_d = mode_s;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_WR;
        end
      end
      ST_WR: begin
        if (!mgmt.mgmt_waitrequest) begin
          if (idx_q == LAST_IDX) begin
            timer_d = '0;
            state_d = ST_SETTLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_WR_GAP;
          end
        end
      end
      ST_WR_GAP: begin
        state_d = ST_WR;
      end
      ST_SETTLE: begin
        // Lock is not sampled here: it is still the stale pre-START lock.
        if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          done_d  = 1'b1;
          error_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (timer_q >= TIMEOUT_LAST) begin
          // applied_q keeps the target: no automatic retry after a timeout.
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      target_q  <= 1'b0;
      applied_q <= 1'b0;
      idx_q     <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      applied_q <= applied_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Decoded from the state flop so the async reset drops the strobe at once;
  // address/data are held at zero whenever no write is presented.
  assign wr_active           = (state_q == ST_WR);
  assign mgmt.mgmt_write     = wr_active;
  assign mgmt.mgmt_address   = wr_active ? entry.addr : '0;
  assign mgmt.mgmt_writedata = wr_active ? entry.data : '0;

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb/tb_pll_reconfig_seq.sv - scoreboard bench for pll_reconfig_seq
module tb_pll_reconfig_seq;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 65535;
  localparam logic [5:0] START_ADDR = 6'd2;
  localparam logic [5:0] SCRIPT_ADDR [8] = '{6'd0, 6'd4, 6'd5, 6'd5, 6'd5, 6'd5, 6'd7, 6'd2};
  localparam logic [31:0] NTSC_DATA [8] = '{32'h0000_0000, 32'h0000_0909, 32'h0000_0303,
    32'h0004_0606, 32'h0008_0C0C, 32'h000C_4848, 32'h6D3A_06D4, 32'h0000_0001};
  localparam logic [31:0] PAL_DATA [8] = '{32'h0000_0000, 32'h0000_0A09, 32'h0000_0403,
    32'h0004_0707, 32'h0008_0E0E, 32'h000C_3C3C, 32'h1E0F_5A2B, 32'h0000_0001};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode_sel = 1'b0;
  logic pll_locked = 1'b1;
  logic busy, done, error;

  pll_reconfig_seq_if mif();

  pll_reconfig_seq dut (
    .refclk     (clk),
    .rst        (rst),
    .mode_sel   (mode_sel),
    .pll_locked (pll_locked),
    .mgmt       (mif),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int n_ends = 0;
  int last_end = 0;

  logic [5:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_start[$];
  int          exp_end_cyc[$];
  bit          exp_end_err[$];

  int stall_mode = 0;
  bit hold_stall = 0;
  bit pll_fail = 0;
  int pll_delay_fixed = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_seq(input bit pal);
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(SCRIPT_ADDR[i]);
      exp_data.push_back(pal ? PAL_DATA[i] : NTSC_DATA[i]);
    end
  endtask

  // Two synchroniser edges plus one decision edge after the pin changes.
  task automatic switch_mode(input bit m);
    @(posedge clk); #2;
    mode_sel = m;
    exp_start.push_back(cyc + 3);
    push_seq(m);
  endtask

  task automatic wait_ends(input int n, input int budget);
    int target;
    int waited;
    target = n_ends + n;
    waited = 0;
    while (n_ends < target && waited < budget) begin
      @(posedge clk);
      waited++;
    end
    check(n_ends >= target, "sequence_end_wait", n_ends, target);
  endtask

  // Controller model: stall each write by 0, 3 or random 0..3 cycles.
  int  stall_left = 0;
  bit  in_write = 0;
  initial mif.mgmt_waitrequest = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      in_write = 0;
      mif.mgmt_waitrequest = hold_stall;
    end else if (mif.mgmt_write) begin
      if (!in_write) begin
        in_write = 1;
        stall_left = (stall_mode == 0) ? 0 : (stall_mode == 1) ? 3 : int'($urandom_range(0, 3));
      end
      if (hold_stall) begin
        mif.mgmt_waitrequest = 1'b1;
      end else if (stall_left > 0) begin
        mif.mgmt_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mif.mgmt_waitrequest = 1'b0;
        in_write = 0;
      end
    end else begin
      in_write = 0;
      mif.mgmt_waitrequest = hold_stall ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // PLL model: on START acceptance drop lock, relock d cycles later (or never).
  // Lock becomes visible two synchroniser edges after the pin rises, but is
  // only honoured after the settle window, i.e. no earlier than START+settle+1.
  always begin
    int es;
    int d;
    @(posedge clk); #2;
    if (!rst && mif.mgmt_write && !mif.mgmt_waitrequest && mif.mgmt_address == START_ADDR) begin
      es = cyc + 1;
      pll_locked = 1'b0;
      if (pll_fail) begin
        exp_end_err.push_back(1'b1);
        exp_end_cyc.push_back(es + SETTLE + TIMEOUT);
      end else begin
        d = (pll_delay_fixed > 0) ? pll_delay_fixed : int'($urandom_range(1, 40));
        exp_end_err.push_back(1'b0);
        exp_end_cyc.push_back(es + ((d + 2 > SETTLE + 1) ? d + 2 : SETTLE + 1));
        repeat (d) @(posedge clk);
        #2;
        pll_locked = 1'b1;
      end
    end
  end

  // Monitor: compares everything the DUT presents against the queues.
  logic        prev_stall = 0, prev_write = 0, prev_busy = 0, prev_error = 0, prev_done = 0;
  logic [5:0]  prev_addr = 0;
  logic [31:0] prev_data = 0;
  bit          gap_track = 0;
  int          gap_len = 0;
  always @(negedge clk) begin
    int e;
    logic [5:0] ea;
    logic [31:0] ed;
    bit k;
    if (rst) begin
      prev_stall = 0; prev_write = 0; prev_busy = 0; prev_error = 0; prev_done = 0;
      gap_track = 0;
    end else begin
      if (prev_stall)
        check(mif.mgmt_write && mif.mgmt_address == prev_addr && mif.mgmt_writedata == prev_data,
              "stall_hold", {mif.mgmt_write, mif.mgmt_address, mif.mgmt_writedata}, {1'b1, prev_addr, prev_data});
      if (gap_track) begin
        if (!mif.mgmt_write) gap_len++;
        else begin
          check(gap_len == 1, "write_gap", gap_len, 1);
          gap_track = 0;
        end
      end
      if (mif.mgmt_write && !prev_write && !prev_busy) begin
        if (exp_start.size() == 0) check(1'b0, "unexpected_start", cyc, 0);
        else begin
          e = exp_start.pop_front();
          if (e < 0) e = last_end + 1;
          check(cyc == e, "start_latency", cyc, e);
        end
      end
      if (mif.mgmt_write && !mif.mgmt_waitrequest) begin
        if (exp_addr.size() == 0) check(1'b0, "unexpected_write", {mif.mgmt_address, mif.mgmt_writedata}, 0);
        else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          check({busy, mif.mgmt_address, mif.mgmt_writedata} == {1'b1, ea, ed}, "write_addr_data",
                {busy, mif.mgmt_address, mif.mgmt_writedata}, {1'b1, ea, ed});
        end
        if (mif.mgmt_address != START_ADDR) begin
          gap_track = 1;
          gap_len = 0;
        end
      end
      if (prev_done) check(!done, "done_width", done, 0);
      if (done || (error && !prev_error)) begin
        n_ends++;
        last_end = cyc;
        if (exp_end_cyc.size() == 0) check(1'b0, "unexpected_end", {cyc, busy, done, error}, 0);
        else begin
          e = exp_end_cyc.pop_front();
          k = exp_end_err.pop_front();
          check({cyc, busy, done, error} == {e, 1'b0, !k, k}, "end_event",
                {cyc, busy, done, error}, {e, 1'b0, !k, k});
        end
      end
      prev_stall = mif.mgmt_write && mif.mgmt_waitrequest;
      prev_write = mif.mgmt_write;
      prev_busy  = busy;
      prev_error = error;
      prev_done  = done;
      prev_addr  = mif.mgmt_address;
      prev_data  = mif.mgmt_writedata;
    end
  end

  initial begin
    int waited;
    int c0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Idle after reset with NTSC selected: nothing moves.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check({mif.mgmt_write, mif.mgmt_address, mif.mgmt_writedata, busy, done, error} == 42'd0, "idle_outputs",
            {mif.mgmt_write, mif.mgmt_address, mif.mgmt_writedata, busy, done, error}, 0);
    end

    // NTSC -> PAL, no stalls, stale lock held through settle.
    stall_mode = 0; pll_delay_fixed = 1;
    switch_mode(1);
    wait_ends(1, 500);

    // PAL -> NTSC, three stall cycles on every write.
    stall_mode = 1; pll_delay_fixed = 25;
    switch_mode(0);
    wait_ends(1, 500);

    // NTSC -> PAL with no relock: timeout, then a good switch clears error.
    stall_mode = 0; pll_delay_fixed = 0; pll_fail = 1;
    switch_mode(1);
    wait_ends(1, 70000);
    pll_fail = 0;
    repeat (20) @(negedge clk);
    check({error, busy, done} == 3'b100, "error_sticky", {error, busy, done}, 3'b100);
    switch_mode(0);
    wait_ends(1, 500);

    // Selection flips back during the third PAL write: PAL finishes, NTSC follows.
    stall_mode = 2;
    switch_mode(1);
    waited = 0;
    do begin
      @(posedge clk); #2;
      waited++;
    end while (!(mif.mgmt_write && mif.mgmt_address == 6'd5) && waited < 200);
    mode_sel = 1'b0;
    push_seq(0);
    exp_start.push_back(-1);
    wait_ends(2, 1500);

    // Randomised switches.
    for (int it = 0; it < 10; it++) begin
      stall_mode = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      switch_mode(!mode_sel);
      wait_ends(1, 1000);
    end

    // Reset while a write is stalled, then a full PAL rerun.
    if (mode_sel) begin
      switch_mode(0);
      wait_ends(1, 1000);
    end
    hold_stall = 1;
    switch_mode(1);
    waited = 0;
    do begin
      @(posedge clk); #2;
      waited++;
    end while (!mif.mgmt_write && waited < 20);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check({mif.mgmt_write, busy} == 2'b00, "reset_async_drop", {mif.mgmt_write, busy}, 0);
    exp_addr.delete(); exp_data.delete(); exp_start.delete();
    exp_end_cyc.delete(); exp_end_err.delete();
    hold_stall = 0;
    stall_mode = 2;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    c0 = cyc;
    exp_start.push_back(c0 + 3);
    push_seq(1);
    wait_ends(1, 1000);

    repeat (10) @(posedge clk);
    check(exp_addr.size() == 0, "writes_outstanding", exp_addr.size(), 0);
    check(exp_end_cyc.size() == 0, "ends_outstanding", exp_end_cyc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
